alpha_fade_ctrl: RTL and testbench

Frame-synchronous controller that sequences the blend weight (alpha) used by the object/background alpha-blend datapath. It accepts fade-in and fade-out requests and ramps alpha one step at a time on frame boundaries. Alpha never changes mid-frame, so there is no tearing. It sits between game/control logic and the pixel blend path, and drives that path's alpha input as a registered value.

---
 rtl/alpha_fade_ctrl_pkg.sv | 25 ++
 rtl/alpha_fade_ctrl_frame_tick_counter.sv | 40 ++++
 rtl/alpha_fade_ctrl.sv | 146 ++++++++++++++
 tb/tb_alpha_fade_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alpha_fade_ctrl_pkg.sv
// Shared types for the alpha fade controller: FSM state and pending-request encodings.
package alpha_fade_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HIDDEN   = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_SHOWN    = 2'd2,
    ST_FADE_OUT = 2'd3
  } fade_state_e;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_IN   = 2'd1,
    PEND_OUT  = 2'd2
  } pend_e;

  function automatic logic is_fading(fade_state_e s);
    return (s == ST_FADE_IN) || (s == ST_FADE_OUT);
  endfunction

  function automatic int cnt_width(int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/alpha_fade_ctrl_frame_tick_counter.sv
// Modulo-MODULUS frame counter: advances when told, wraps to 0 after MODULUS-1,
// and flags the terminal count so the caller can act on the wrapping frame.
module frame_tick_counter
  import alpha_fade_ctrl_pkg::*;
#(
  parameter int MODULUS = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic advance,
  output logic tc
);

  localparam int W = cnt_width(MODULUS);
  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = tc ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alpha_fade_ctrl.sv
// Frame-synchronous alpha fade sequencer: latches fade requests and steps the
// registered blend weight only on frame_start so alpha never changes mid-frame.
module alpha_fade_ctrl
  import alpha_fade_ctrl_pkg::*;
#(
  parameter int ALPHA_BITS      = 4,
  parameter int FRAMES_PER_STEP = 2,
  parameter int HOLD_FRAMES     = 60
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_start,
  input  logic                  fade_in_req,
  input  logic                  fade_out_req,
  input  logic                  auto_hide,
  output logic [ALPHA_BITS:0]   alpha,
  output logic                  busy,
  output logic                  fade_done,
  output logic [1:0]            state
);

  localparam int AW = ALPHA_BITS + 1;
  localparam logic [AW-1:0] ALPHA_ONE = AW'(1);
  localparam logic [AW-1:0] ALPHA_MAX = ALPHA_ONE << ALPHA_BITS;

  fade_state_e     state_q, state_d;
  logic [AW-1:0]   alpha_q, alpha_d;
  pend_e           pend_q, pend_d;
  logic            done_q, done_d;

  pend_e           pend_eff;
  logic            go_in, go_out;
  logic            step_clear, step_adv, step_tc;
  logic            hold_clear, hold_adv, hold_tc;

  frame_tick_counter #(.MODULUS(FRAMES_PER_STEP)) u_step_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (step_clear),
    .advance (step_adv),
    .tc      (step_tc)
  );

  frame_tick_counter #(.MODULUS(HOLD_FRAMES)) u_hold_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (hold_clear),
    .advance (hold_adv),
    .tc      (hold_tc)
  );

  always_comb begin
    // A request in the same cycle as frame_start is acted on at that frame.
    pend_eff = pend_q;
    if (fade_in_req && !fade_out_req) begin
      pend_eff = PEND_IN;
    end else if (fade_out_req && !fade_in_req) begin
      pend_eff = PEND_OUT;
    end

    state_d    = state_q;
    alpha_d    = alpha_q;
    pend_d     = pend_eff;
    done_d     = 1'b0;
    go_in      = 1'b0;
    go_out     = 1'b0;
    step_clear = 1'b0;
    step_adv   = 1'b0;
    hold_clear = 1'b0;
    hold_adv   = 1'b0;

    if (frame_start) begin
      pend_d = PEND_NONE;
      go_in  = (pend_eff == PEND_IN)  && (state_q == ST_HIDDEN || state_q == ST_FADE_OUT);
      go_out = (pend_eff == PEND_OUT) && (state_q == ST_SHOWN  || state_q == ST_FADE_IN);

      if (go_in) begin
        state_d    = ST_FADE_IN;
        step_clear = 1'b1;
      end else if (go_out) begin
        state_d    = ST_FADE_OUT;
        step_clear = 1'b1;
      end else begin
        case (state_q)
          ST_SHOWN: begin
            if (auto_hide) begin
              hold_adv = 1'b1;
              if (hold_tc) begin
                state_d    = ST_FADE_OUT;
                step_clear = 1'b1;
              end
            end
          end
          ST_FADE_IN: begin
            step_adv = 1'b1;
            if (step_tc) begin
              if (alpha_q >= ALPHA_MAX - ALPHA_ONE) begin
                alpha_d    = ALPHA_MAX;
                state_d    = ST_SHOWN;
                done_d     = 1'b1;
                hold_clear = 1'b1;
              end else begin
                alpha_d = alpha_q + ALPHA_ONE;
              end
            end
          end
          ST_FADE_OUT: begin
            step_adv = 1'b1;
            if (step_tc) begin
              if (alpha_q <= ALPHA_ONE) begin
                alpha_d = '0;
                state_d = ST_HIDDEN;
                done_d  = 1'b1;
              end else begin
                alpha_d = alpha_q - ALPHA_ONE;
              end
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_HIDDEN;
      alpha_q <= '0;
      pend_q  <= PEND_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alpha_q <= alpha_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  assign alpha     = alpha_q;
  assign busy      = is_fading(state_q);
  assign fade_done = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_alpha_fade_ctrl.sv
// Bench for alpha_fade_ctrl: directed test-plan scenarios with literal checks,
// then randomized traffic, all scored every cycle against a frame-level model.
module tb_alpha_fade_ctrl;

  localparam int AB   = 4;
  localparam int FPS  = 2;
  localparam int HOLD = 3;
  localparam int AMAX = 16;
  localparam int W    = 9;

  logic          clk          = 1'b0;
  logic          reset_n      = 1'b0;
  logic          frame_start  = 1'b0;
  logic          fade_in_req  = 1'b0;
  logic          fade_out_req = 1'b0;
  logic          auto_hide    = 1'b0;
  logic [AB:0]   alpha;
  logic          busy;
  logic          fade_done;
  logic [1:0]    state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  // model: 0 hidden, 1 fading in, 2 shown, 3 fading out; pend 0 none, 1 in, 2 out
  int m_st    = 0;
  int m_alpha = 0;
  int m_pend  = 0;
  int m_sub   = 0;
  int m_hold  = 0;
  bit m_done  = 1'b0;

  alpha_fade_ctrl #(
    .ALPHA_BITS      (AB),
    .FRAMES_PER_STEP (FPS),
    .HOLD_FRAMES     (HOLD)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
    .fade_in_req  (fade_in_req),
    .fade_out_req (fade_out_req),
    .auto_hide    (auto_hide),
    .alpha        (alpha),
    .busy         (busy),
    .fade_done    (fade_done),
    .state        (state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // behavioural model, evaluated once per clock edge
  always @(posedge clk) begin
    int req;
    int dir;
    m_done = 1'b0;
    if (!reset_n) begin
      m_st = 0; m_alpha = 0; m_pend = 0; m_sub = 0; m_hold = 0;
    end else begin
      if (fade_in_req != fade_out_req) m_pend = fade_in_req ? 1 : 2;
      if (frame_start) begin
        req = m_pend;
        m_pend = 0;
        if (req == 1 && (m_st == 0 || m_st == 3)) begin
          m_st = 1; m_sub = 0;
        end else if (req == 2 && (m_st == 2 || m_st == 1)) begin
          m_st = 3; m_sub = 0;
        end else if (m_st == 2) begin
          if (auto_hide) begin
            m_hold = m_hold + 1;
            if (m_hold == HOLD) begin
              m_st = 3; m_sub = 0;
            end
          end
        end else if (m_st == 1 || m_st == 3) begin
          m_sub = m_sub + 1;
          if (m_sub == FPS) begin
            m_sub = 0;
            dir = (m_st == 1) ? 1 : -1;
            m_alpha = m_alpha + dir;
            if (m_alpha > AMAX) m_alpha = AMAX;
            if (m_alpha < 0) m_alpha = 0;
            if (m_st == 1 && m_alpha == AMAX) begin
              m_st = 2; m_hold = 0; m_done = 1'b1;
            end else if (m_st == 3 && m_alpha == 0) begin
              m_st = 0; m_done = 1'b1;
            end
          end
        end
      end
    end
    exp_q.push_back({2'(m_st), 1'(m_st == 1 || m_st == 3), m_done, 5'(m_alpha)});
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, busy, fade_done, alpha};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL scoreboard @%0t: got st=%0d busy=%0b done=%0b alpha=%0d, expected st=%0d busy=%0b done=%0b alpha=%0d",
                    $time, a[8:7], a[6], a[5], a[4:0], e[8:7], e[6], e[5], e[4:0]);
    end
  end

  task automatic check_lit(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  // driver tasks; each returns at the negedge right after the last sampled edge
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
  endtask

  task automatic req(input logic in_r, input logic out_r);
    @(negedge clk);
    fade_in_req  = in_r;
    fade_out_req = out_r;
    @(negedge clk);
    fade_in_req  = 1'b0;
    fade_out_req = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_lit("reset_alpha", int'(alpha), 0);
    check_lit("reset_state", int'(state), 0);

    frames(5);
    check_lit("idle_alpha", int'(alpha), 0);
    check_lit("idle_state", int'(state), 0);
    check_lit("idle_busy", int'(busy), 0);

    req(1'b1, 1'b0);
    frames(1);
    check_lit("fi_entry_state", int'(state), 1);
    check_lit("fi_entry_alpha", int'(alpha), 0);
    frames(2);
    check_lit("fi_f3_alpha", int'(alpha), 1);
    frames(30);
    check_lit("fi_f33_alpha", int'(alpha), AMAX);
    check_lit("fi_f33_state", int'(state), 2);
    check_lit("fi_f33_done", int'(fade_done), 1);
    check_lit("fi_f33_busy", int'(busy), 0);
    @(negedge clk);
    check_lit("fi_done_single", int'(fade_done), 0);

    auto_hide = 1'b1;
    frames(2);
    check_lit("hold_2_state", int'(state), 2);
    frames(1);
    check_lit("hold_3_state", int'(state), 3);
    check_lit("hold_3_alpha", int'(alpha), AMAX);
    frames(31);
    check_lit("fo_31_alpha", int'(alpha), 1);
    frames(1);
    check_lit("fo_32_alpha", int'(alpha), 0);
    check_lit("fo_32_state", int'(state), 0);
    check_lit("fo_32_done", int'(fade_done), 1);
    auto_hide = 1'b0;

    req(1'b1, 1'b0);
    frames(15);
    check_lit("rev_pre_alpha", int'(alpha), 7);
    req(1'b0, 1'b1);
    frames(1);
    check_lit("rev_state", int'(state), 3);
    check_lit("rev_alpha", int'(alpha), 7);
    check_lit("rev_no_done", int'(fade_done), 0);
    frames(2);
    check_lit("rev_step_alpha", int'(alpha), 6);

    pulse_reset();
    req(1'b1, 1'b1);
    frames(1);
    check_lit("both_req_state", int'(state), 0);
    check_lit("both_req_alpha", int'(alpha), 0);

    req(1'b1, 1'b0);
    frames(19);
    check_lit("rst_pre_alpha", int'(alpha), 9);
    req(1'b1, 1'b0);
    pulse_reset();
    check_lit("rst_alpha", int'(alpha), 0);
    check_lit("rst_state", int'(state), 0);
    check_lit("rst_busy", int'(busy), 0);
    check_lit("rst_done", int'(fade_done), 0);
    frames(1);
    check_lit("rst_pend_dropped", int'(state), 0);

    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      frame_start  = ($urandom_range(0, 3) == 0);
      fade_in_req  = ($urandom_range(0, 59) == 0);
      fade_out_req = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 99) == 0) auto_hide = ~auto_hide;
      reset_n = ($urandom_range(0, 1499) != 0);
    end
    @(negedge clk);
    frame_start  = 1'b0;
    fade_in_req  = 1'b0;
    fade_out_req = 1'b0;
    reset_n      = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
